// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM between SPI command frames and a local parallel port.
// Optional ARB_FIXED_PRIO_EN: the SPI job always wins ties (no round-robin state).
module spi_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH+1:0] rx_data,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  loc_req,
  input  logic                  loc_we,
  input  logic [ADDR_WIDTH-1:0] loc_addr,
  input  logic [DATA_WIDTH-1:0] loc_wdata,
  output logic                  loc_gnt,
  output logic                  loc_rvalid,
  output logic [DATA_WIDTH-1:0] loc_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  spi_ovf,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdata} state_e;

  localparam logic [1:0] CmdWrAddr = 2'b00;
  localparam logic [1:0] CmdWrite  = 2'b01;
  localparam logic [1:0] CmdRdAddr = 2'b10;
  localparam logic [1:0] CmdRead   = 2'b11;

  state_e                state_q, state_d;
  logic                  slot_full_q, slot_full_d;
  logic                  slot_we_q, slot_we_d;
  logic [ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
  logic [DATA_WIDTH-1:0] slot_wdata_q, slot_wdata_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  op_we_q, op_we_d;
  logic                  op_spi_q, op_spi_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] loc_rdata_q, loc_rdata_d;
  logic                  loc_rvalid_q, loc_rvalid_d;
  logic                  spi_ovf_q, spi_ovf_d;

  logic [1:0]            cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic                  spi_win;
  logic                  slot_clear;
  logic                  post_ok;

  assign cmd     = rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign payload = rx_data[DATA_WIDTH-1:0];

`ifdef ARB_FIXED_PRIO_EN
  assign spi_win = slot_full_q;
`else
  // rr_spi_q records the last winner; a tie goes to the other requester.
  logic rr_spi_q, rr_spi_d;
  assign spi_win = slot_full_q && (!loc_req || !rr_spi_q);
`endif

  // The slot frees in the ACCESS cycle of an SPI op, so a frame arriving then still fits.
  assign slot_clear = (state_q == StAccess) && op_spi_q;
  assign post_ok    = !slot_full_q || slot_clear;

  always_comb begin
    state_d      = state_q;
    slot_full_d  = slot_full_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    op_we_d      = op_we_q;
    op_spi_d     = op_spi_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    loc_rdata_d  = loc_rdata_q;
    loc_rvalid_d = 1'b0;
    spi_ovf_d    = spi_ovf_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_spi_d     = rr_spi_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (slot_full_q || loc_req) begin
          state_d  = StAccess;
          op_spi_d = spi_win;
`ifndef ARB_FIXED_PRIO_EN
          rr_spi_d = spi_win;
`endif
          if (spi_win) begin
            op_we_d    = slot_we_q;
            mem_addr_d = slot_addr_q;
            if (slot_we_q) mem_wdata_d = slot_wdata_q;
          end else begin
            op_we_d    = loc_we;
            mem_addr_d = loc_addr;
            if (loc_we) mem_wdata_d = loc_wdata;
          end
        end
      end
      StAccess: state_d = op_we_q ? StIdle : StRdata;
      StRdata: begin
        state_d = StIdle;
        if (op_spi_q) begin
          tx_data_d  = mem_rdata;
          tx_valid_d = 1'b1;
        end else begin
          loc_rdata_d  = mem_rdata;
          loc_rvalid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (slot_clear) slot_full_d = 1'b0;

    if (rx_valid) begin
      unique case (cmd)
        CmdWrAddr: wr_addr_d = payload;
        CmdRdAddr: rd_addr_d = payload;
        CmdWrite: begin
          if (post_ok) begin
            slot_full_d  = 1'b1;
            slot_we_d    = 1'b1;
            slot_addr_d  = wr_addr_q;
            slot_wdata_d = payload;
            wr_addr_d    = wr_addr_q + ADDR_WIDTH'(1);
          end else begin
            spi_ovf_d = 1'b1;
          end
        end
        CmdRead: begin
          if (post_ok) begin
            slot_full_d = 1'b1;
            slot_we_d   = 1'b0;
            slot_addr_d = rd_addr_q;
            rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
          end else begin
            spi_ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      slot_full_q  <= 1'b0;
      slot_we_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      op_we_q      <= 1'b0;
      op_spi_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      loc_rdata_q  <= '0;
      loc_rvalid_q <= 1'b0;
      spi_ovf_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_spi_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      slot_full_q  <= slot_full_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      op_we_q      <= op_we_d;
      op_spi_q     <= op_spi_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      loc_rdata_q  <= loc_rdata_d;
      loc_rvalid_q <= loc_rvalid_d;
      spi_ovf_q    <= spi_ovf_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_spi_q     <= rr_spi_d;
`endif
    end
  end

  assign mem_en     = (state_q == StAccess);
  assign mem_we     = mem_en && op_we_q;
  assign loc_gnt    = mem_en && !op_spi_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign loc_rdata  = loc_rdata_q;
  assign loc_rvalid = loc_rvalid_q;
  assign spi_ovf    = spi_ovf_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: a transaction-level model predicts every RAM access,
// grant and read return; a negedge monitor compares what the DUT presents.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       loc_req;
  logic       loc_we;
  logic [7:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_gnt;
  logic       loc_rvalid;
  logic [7:0] loc_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       spi_ovf;
  logic       busy;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .loc_req   (loc_req),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .loc_gnt   (loc_gnt),
    .loc_rvalid(loc_rvalid),
    .loc_rdata (loc_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .spi_ovf   (spi_ovf),
    .busy      (busy)
  );

  // Environment RAM: read data appears the cycle after a read access.
  bit [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  typedef struct { int cyc; bit we; bit [7:0] addr; bit [7:0] data; } mem_exp_t;
  typedef struct { int cyc; bit [7:0] data; } rd_exp_t;

  mem_exp_t exp_mem[$];
  rd_exp_t  exp_tx[$];
  rd_exp_t  exp_loc[$];
  int       exp_gnt[$];
  string    dq_name[$];
  int       dq_sel[$];
  int       dq_exp[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: job slot, SPI address registers, last winner, busy window.
  bit       m_slot;
  bit       m_job_we;
  bit [7:0] m_job_addr;
  bit [7:0] m_job_data;
  bit [7:0] m_wr;
  bit [7:0] m_rd;
  bit       m_ovf;
  bit       m_last_loc = 1'b1;
  int       m_free_at;
  int       m_busy_from;
  int       m_spi_acc = -1;
  bit [7:0] m_ram [256];

  task automatic model_op(input bit spi, input bit we, input bit [7:0] a, input bit [7:0] d,
                          input int c);
    mem_exp_t e;
    rd_exp_t  r;
    e.cyc = c + 1; e.we = we; e.addr = a; e.data = d;
    exp_mem.push_back(e);
    m_busy_from = c + 1;
    if (we) begin
      m_ram[a]  = d;
      m_free_at = c + 2;
    end else begin
      r.cyc = c + 3; r.data = m_ram[a];
      if (spi) exp_tx.push_back(r);
      else exp_loc.push_back(r);
      m_free_at = c + 3;
    end
  endtask

  always @(posedge clk) begin : model
    bit freed;
    bit spi_win;
    bit post;
    int c;
    c = cyc;
    post = 1'b0;
    if (rst) begin
      m_slot = 1'b0; m_wr = '0; m_rd = '0; m_ovf = 1'b0; m_last_loc = 1'b1;
      m_free_at = 0; m_busy_from = 0; m_spi_acc = -1;
      exp_mem.delete(); exp_tx.delete(); exp_loc.delete(); exp_gnt.delete();
    end else begin
      freed = (m_spi_acc == c);
      if (c >= m_free_at && (m_slot || loc_req)) begin
`ifdef ARB_FIXED_PRIO_EN
        spi_win = m_slot;
`else
        spi_win = m_slot && (!loc_req || m_last_loc);
        m_last_loc = !spi_win;
`endif
        if (spi_win) begin
          model_op(1'b1, m_job_we, m_job_addr, m_job_data, c);
          m_spi_acc = c + 1;
        end else begin
          model_op(1'b0, loc_we, loc_addr, loc_wdata, c);
          exp_gnt.push_back(c + 1);
        end
      end
      if (rx_valid) begin
        case (rx_data[9:8])
          2'b00: m_wr = rx_data[7:0];
          2'b10: m_rd = rx_data[7:0];
          default: begin
            if (!m_slot || freed) begin
              post = 1'b1;
              m_job_we = (rx_data[9:8] == 2'b01);
              m_job_data = rx_data[7:0];
              if (m_job_we) begin m_job_addr = m_wr; m_wr = m_wr + 8'd1; end
              else begin m_job_addr = m_rd; m_rd = m_rd + 8'd1; end
            end else begin
              m_ovf = 1'b1;
            end
          end
        endcase
      end
      if (post) m_slot = 1'b1;
      else if (freed) m_slot = 1'b0;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  bit [7:0] tx_hold = '0;
  bit [7:0] loc_hold = '0;

  always @(negedge clk) begin : monitor
    mem_exp_t e;
    rd_exp_t  r;
    int       g;
    int       sel;
    int       act;
    if (cyc > 0) begin
      if (mem_en) begin
        if (exp_mem.size() == 0) chk("mem_unexpected", exp_mem.size(), 1);
        else begin
          e = exp_mem.pop_front();
          chk("mem_cycle", cyc, e.cyc);
          chk("mem_we", int'(mem_we), int'(e.we));
          chk("mem_addr", int'(mem_addr), int'(e.addr));
          if (e.we) chk("mem_wdata", int'(mem_wdata), int'(e.data));
        end
      end
      while (exp_mem.size() > 0 && exp_mem[0].cyc < cyc) begin
        chk("mem_missed", cyc, exp_mem[0].cyc);
        void'(exp_mem.pop_front());
      end
      if (tx_valid) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", exp_tx.size(), 1);
        else begin
          r = exp_tx.pop_front();
          chk("tx_cycle", cyc, r.cyc);
          chk("tx_data", int'(tx_data), int'(r.data));
          tx_hold = r.data;
        end
      end
      while (exp_tx.size() > 0 && exp_tx[0].cyc < cyc) begin
        chk("tx_missed", cyc, exp_tx[0].cyc);
        void'(exp_tx.pop_front());
      end
      if (loc_rvalid) begin
        if (exp_loc.size() == 0) chk("loc_rvalid_unexpected", exp_loc.size(), 1);
        else begin
          r = exp_loc.pop_front();
          chk("loc_rvalid_cycle", cyc, r.cyc);
          chk("loc_rdata", int'(loc_rdata), int'(r.data));
          loc_hold = r.data;
        end
      end
      while (exp_loc.size() > 0 && exp_loc[0].cyc < cyc) begin
        chk("loc_rvalid_missed", cyc, exp_loc[0].cyc);
        void'(exp_loc.pop_front());
      end
      if (loc_gnt) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", exp_gnt.size(), 1);
        else begin
          g = exp_gnt.pop_front();
          chk("gnt_cycle", cyc, g);
        end
      end
      while (exp_gnt.size() > 0 && exp_gnt[0] < cyc) begin
        chk("gnt_missed", cyc, exp_gnt[0]);
        void'(exp_gnt.pop_front());
      end
      chk("tx_data_hold", int'(tx_data), int'(tx_hold));
      chk("loc_rdata_hold", int'(loc_rdata), int'(loc_hold));
      chk("busy", int'(busy), int'(cyc >= m_busy_from && cyc < m_free_at));
      chk("spi_ovf", int'(spi_ovf), int'(m_ovf));
      while (dq_sel.size() > 0) begin
        sel = dq_sel.pop_front();
        case (sel)
          0: act = int'({mem_en, mem_we, loc_gnt, tx_valid, loc_rvalid, busy, spi_ovf,
                         |mem_addr, |mem_wdata, |tx_data, |loc_rdata});
          1: act = int'(spi_ovf);
          2: act = int'(tx_data);
          default: act = exp_mem.size() + exp_tx.size() + exp_loc.size() + exp_gnt.size();
        endcase
        chk(dq_name.pop_front(), act, dq_exp.pop_front());
      end
      if (rst) begin
        tx_hold = '0;
        loc_hold = '0;
      end
    end
  end

  task automatic dpush(input string name, input int sel, input int exp);
    dq_name.push_back(name);
    dq_sel.push_back(sel);
    dq_exp.push_back(exp);
  endtask

  task automatic step();
    bit g;
    @(negedge clk);
    g = loc_gnt;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (g) loc_req = 1'b0;
  endtask

  task automatic frame(input bit [1:0] cmd, input bit [7:0] p);
    rx_valid = 1'b1;
    rx_data = {cmd, p};
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    loc_req = 1'b0;
    step();
    rst = 1'b0;
    dpush(name, 0, 0);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    step();
    do_reset("reset_state");

    // Address load then writes with auto-increment.
    frame(2'b00, 8'h10); frame(2'b01, 8'hA5); idle(3); frame(2'b01, 8'h3C); idle(4);

    // Local write seeds 0x5A, then SPI read of 0x10.
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h10; loc_wdata = 8'h5A;
    idle(3);
    frame(2'b10, 8'h10); frame(2'b11, 8'h77); idle(6);
    dpush("spi_read_data", 2, 8'h5A);

    // Two writes during a local read: the second overflows.
    do_reset("reset_before_ovf");
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10;
    step();
    frame(2'b01, 8'h11); frame(2'b01, 8'h22); idle(6);
    dpush("ovf_sticky", 1, 1);
    frame(2'b01, 8'h33); idle(4);

    // Address wrap 0xFF -> 0x00.
    frame(2'b00, 8'hFF); frame(2'b01, 8'h01); idle(3); frame(2'b01, 8'h02); idle(4);

    // Continuous SPI reads against a continuously requesting local port.
    do_reset("reset_before_arb");
    for (int i = 0; i < 16; i++) begin
      if (!loc_req) begin
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'hC0 + 8'(i);
      end
      rx_valid = 1'b1; rx_data = {2'b11, 8'h00};
      step();
    end
    idle(6);

    // Reset in the RDATA cycle of an SPI read and of a local read.
    do_reset("reset_before_abort");
    frame(2'b11, 8'h00); step(); step();
    do_reset("abort_spi_read");
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h05;
    step(); step();
    do_reset("abort_loc_read");

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) loc_req = 1'b0;
      else if (!loc_req && $urandom_range(0, 2) == 0) begin
        loc_req = 1'b1; loc_we = 1'($urandom);
        loc_addr = 8'($urandom); loc_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        rx_valid = 1'b1; rx_data = 10'($urandom);
      end
      step();
    end
    rst = 1'b0;
    idle(12);
    dpush("drain_empty", 3, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
